// File: rtl/vga_sprite_renderer.sv
// vga_sprite_renderer: double-buffered sprite compositor, 2-strobe pixel pipeline.
// Optional feature macro: SPRITE_COLLISION_EN (per-frame sprite overlap flag).
module vga_sprite_renderer #(
    parameter int                 NUM_SPRITES = 8,
    parameter int                 X_W         = 10,
    parameter int                 Y_W         = 10,
    parameter int                 SZ_W        = 7,
    parameter int                 COLOR_W     = 8,
    parameter logic [COLOR_W-1:0] BG_COLOR    = '0
) (
    input  logic                           real100clock,
    input  logic                           reset_n,
    input  logic                           pix_en,
    input  logic [X_W-1:0]                 pix_x,
    input  logic [Y_W-1:0]                 pix_y,
    input  logic                           in_hsync,
    input  logic                           in_vsync,
    input  logic                           in_blank_n,
    input  logic                           cfg_we,
    input  logic [$clog2(NUM_SPRITES)-1:0] cfg_idx,
    input  logic                           cfg_en,
    input  logic [X_W-1:0]                 cfg_x,
    input  logic [Y_W-1:0]                 cfg_y,
    input  logic [SZ_W-1:0]                cfg_w,
    input  logic [SZ_W-1:0]                cfg_h,
    input  logic [COLOR_W-1:0]             cfg_color,
    output logic [COLOR_W-1:0]             out_color,
    output logic                           out_hsync,
    output logic                           out_vsync,
    output logic                           out_blank_n,
    output logic                           frame_commit,
    output logic                           collision
);
    localparam int XW1 = X_W + 1;
    localparam int YW1 = Y_W + 1;

    typedef struct packed {
        logic               en;
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [SZ_W-1:0]    w;
        logic [SZ_W-1:0]    h;
        logic [COLOR_W-1:0] c;
    } spr_t;

    spr_t sh_q  [NUM_SPRITES];
    spr_t sh_d  [NUM_SPRITES];
    spr_t act_q [NUM_SPRITES];
    spr_t act_d [NUM_SPRITES];

    logic               prev_vs_q, prev_vs_d;
    logic [X_W-1:0]     s1_x_q, s1_x_d;
    logic [Y_W-1:0]     s1_y_q, s1_y_d;
    logic               s1_hs_q, s1_hs_d;
    logic               s1_vs_q, s1_vs_d;
    logic               s1_bn_q, s1_bn_d;
    logic [COLOR_W-1:0] out_color_q, out_color_d;
    logic               out_hs_q, out_hs_d;
    logic               out_vs_q, out_vs_d;
    logic               out_bn_q, out_bn_d;

    logic                   commit;
    logic [NUM_SPRITES-1:0] hit;
    logic [COLOR_W-1:0]     pick;
    logic                   found;

    // Falling edge of vsync, seen on a strobe, swaps in the new table.
    assign commit       = pix_en & prev_vs_q & ~in_vsync;
    assign frame_commit = commit;

    assign out_color   = out_color_q;
    assign out_hsync   = out_hs_q;
    assign out_vsync   = out_vs_q;
    assign out_blank_n = out_bn_q;

    // Table update: commit copies the old shadow, a same-cycle write lands after.
    always_comb begin
        sh_d  = sh_q;
        act_d = act_q;
        if (commit) begin
            act_d = sh_q;
        end
        if (cfg_we && (32'(cfg_idx) < 32'(NUM_SPRITES))) begin
            sh_d[cfg_idx] = '{en: cfg_en, x: cfg_x, y: cfg_y,
                              w: cfg_w, h: cfg_h, c: cfg_color};
        end
    end

    // Rectangle test on the stage-1 pixel, widened so edge sprites clip.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            hit[i] = act_q[i].en
                && ({1'b0, s1_x_q} >= {1'b0, act_q[i].x})
                && ({1'b0, s1_x_q} < ({1'b0, act_q[i].x} + XW1'(act_q[i].w)))
                && ({1'b0, s1_y_q} >= {1'b0, act_q[i].y})
                && ({1'b0, s1_y_q} < ({1'b0, act_q[i].y} + YW1'(act_q[i].h)));
        end
    end

    // Lowest-index hit wins.
    always_comb begin
        pick  = BG_COLOR;
        found = 1'b0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (hit[i] && !found) begin
                pick  = act_q[i].c;
                found = 1'b1;
            end
        end
    end

    // Pipeline next state; everything holds between pixel strobes.
    always_comb begin
        prev_vs_d   = prev_vs_q;
        s1_x_d      = s1_x_q;
        s1_y_d      = s1_y_q;
        s1_hs_d     = s1_hs_q;
        s1_vs_d     = s1_vs_q;
        s1_bn_d     = s1_bn_q;
        out_color_d = out_color_q;
        out_hs_d    = out_hs_q;
        out_vs_d    = out_vs_q;
        out_bn_d    = out_bn_q;
        if (pix_en) begin
            prev_vs_d   = in_vsync;
            s1_x_d      = pix_x;
            s1_y_d      = pix_y;
            s1_hs_d     = in_hsync;
            s1_vs_d     = in_vsync;
            s1_bn_d     = in_blank_n;
            out_color_d = s1_bn_q ? pick : '0;
            out_hs_d    = s1_hs_q;
            out_vs_d    = s1_vs_q;
            out_bn_d    = s1_bn_q;
        end
    end

    // State registers; prev_vsync resets low so release never fakes a commit.
    always_ff @(posedge real100clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                sh_q[i]  <= '0;
                act_q[i] <= '0;
            end
            prev_vs_q   <= 1'b0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            s1_hs_q     <= 1'b1;
            s1_vs_q     <= 1'b1;
            s1_bn_q     <= 1'b0;
            out_color_q <= '0;
            out_hs_q    <= 1'b1;
            out_vs_q    <= 1'b1;
            out_bn_q    <= 1'b0;
        end else begin
            sh_q        <= sh_d;
            act_q       <= act_d;
            prev_vs_q   <= prev_vs_d;
            s1_x_q      <= s1_x_d;
            s1_y_q      <= s1_y_d;
            s1_hs_q     <= s1_hs_d;
            s1_vs_q     <= s1_vs_d;
            s1_bn_q     <= s1_bn_d;
            out_color_q <= out_color_d;
            out_hs_q    <= out_hs_d;
            out_vs_q    <= out_vs_d;
            out_bn_q    <= out_bn_d;
        end
    end

`ifdef SPRITE_COLLISION_EN
    logic det;
    logic flag_q, flag_d;
    logic coll_q, coll_d;

    // Two or more hit bits on a visible pixel.
    assign det = s1_bn_q
        && ((hit & (hit - {{(NUM_SPRITES-1){1'b0}}, 1'b1})) != '0);

    // Sticky flag published once per frame; commit-cycle hits start the new frame.
    always_comb begin
        flag_d = flag_q;
        coll_d = coll_q;
        if (pix_en) begin
            if (commit) begin
                coll_d = flag_q;
                flag_d = det;
            end else begin
                flag_d = flag_q | det;
            end
        end
    end

    // Collision registers.
    always_ff @(posedge real100clock or negedge reset_n) begin
        if (!reset_n) begin
            flag_q <= 1'b0;
            coll_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
            coll_q <= coll_d;
        end
    end

    assign collision = coll_q;
`else
    assign collision = 1'b0;
`endif

endmodule
